// File: rtl/snapshot_mem_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : snapshot_mem_bridge_pkg                                        |
// | Purpose : Shared definitions for the snapshot memory bridge:             |
// |           one-hot FSM state encodings with bit indices, a ceil-log2      |
// |           helper and the partition-count derivation.                     |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package snapshot_mem_bridge_pkg;

   localparam int ST_IDLE_BIT = 0;
   localparam int ST_MEM_BIT  = 1;
   localparam int ST_RESP_BIT = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_MEM  = 3'b010,
      ST_RESP = 3'b100
   } state_e;

   // Ceil-log2; returns 0 for inputs of 0 or 1.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Number of register words needed to cover one memory entry.
   function automatic int part_cnt_f(input int mem_w, input int data_w);
      return (mem_w + data_w - 1) / data_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/snapshot_mem_bridge_one_hot_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : one_hot_mux                                                    |
// | Purpose : AND-OR multiplexer selecting one WIDTH-bit slice out of CNT    |
// |           slices with a one-hot select. An all-zero select yields 0.     |
// | Ports   : data_i  CNT concatenated slices, slice 0 in the LSBs           |
// |           sel_i   one-hot slice select                                   |
// |           data_o  selected slice                                         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module one_hot_mux #(
   parameter int WIDTH = 32,
   parameter int CNT   = 3
) (
   input  logic [WIDTH*CNT-1:0] data_i,
   input  logic [CNT-1:0]       sel_i,
   output logic [WIDTH-1:0]     data_o
);

   always_comb begin
      data_o = '0;
      for (int i = 0; i < CNT; i++) begin
         data_o = data_o | (data_i[i*WIDTH +: WIDTH] & {WIDTH{sel_i[i]}});
      end
   end

endmodule
`default_nettype wire

// File: rtl/snapshot_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : snapshot_mem_bridge                                            |
// | Purpose : Bridges register-bus word accesses onto a memory whose entries |
// |           are wider than one word. The trigger partition moves a whole   |
// |           entry between memory and a snapshot buffer; other partitions   |
// |           are served from / staged into the buffer.                      |
// | Ports   : clk, rst_n            clock, async active-low reset            |
// |           req_vld_i/addr_i/rd_en_i/wr_en_i/wr_data_i  bus request        |
// |           ack_vld_o/rd_data_o/err_o                   bus response       |
// |           entry_vld_i, entry_write_protect_en_i       entry qualifiers   |
// |           busy_o                                      FSM not idle       |
// |           mem_req_vld_o/mem_addr_o/mem_rd_en_o/mem_wr_en_o/mem_wr_data_o |
// |           mem_ack_vld_i/mem_rd_data_i                 memory side        |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module snapshot_mem_bridge
   import snapshot_mem_bridge_pkg::*;
#(
   parameter int                   DATA_WIDTH     = 32,
   parameter int                   MEM_WIDTH      = 72,
   parameter int                   ADDR_WIDTH     = 12,
   parameter int                   ENTRY_WIDTH    = 8,
   parameter int unsigned          BASE_ADDR      = 0,
   parameter bit                   TRIGGER_LSB    = 1'b1,
   parameter int                   TIMEOUT_CYCLES = 255,
   parameter logic [MEM_WIDTH-1:0] RST_VALUE      = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_vld_i,
   input  logic [ADDR_WIDTH-1:0]  addr_i,
   input  logic                   rd_en_i,
   input  logic                   wr_en_i,
   input  logic [DATA_WIDTH-1:0]  wr_data_i,
   output logic                   ack_vld_o,
   output logic [DATA_WIDTH-1:0]  rd_data_o,
   output logic                   err_o,
   input  logic                   entry_vld_i,
   input  logic                   entry_write_protect_en_i,
   output logic                   busy_o,
   output logic                   mem_req_vld_o,
   output logic [ENTRY_WIDTH-1:0] mem_addr_o,
   output logic                   mem_rd_en_o,
   output logic                   mem_wr_en_o,
   output logic [MEM_WIDTH-1:0]   mem_wr_data_o,
   input  logic                   mem_ack_vld_i,
   input  logic [MEM_WIDTH-1:0]   mem_rd_data_i
);

   localparam int PARTITION_CNT = part_cnt_f(MEM_WIDTH, DATA_WIDTH);
   localparam int BOFF          = clog2_f(DATA_WIDTH / 8);
   localparam int PB            = (clog2_f(PARTITION_CNT) < 1) ? 1 : clog2_f(PARTITION_CNT);
   localparam int TRIG_PART     = TRIGGER_LSB ? 0 : PARTITION_CNT - 1;
   localparam int CNT_W         = (clog2_f(TIMEOUT_CYCLES + 1) < 1) ? 1 : clog2_f(TIMEOUT_CYCLES + 1);
   localparam int TO_LAST       = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_e                   state_q, state_d;
   logic [MEM_WIDTH-1:0]     snap_q, snap_d;
   logic [PB-1:0]            part_q, part_d;
   logic                     rd_q, rd_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     ack_q, ack_d;
   logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
   logic                     err_q, err_d;
   logic                     mem_req_q, mem_req_d;
   logic [ENTRY_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic                     mem_rd_en_q, mem_rd_en_d;
   logic                     mem_wr_en_q, mem_wr_en_d;
   logic [MEM_WIDTH-1:0]     mem_wr_data_q, mem_wr_data_d;

   logic [ADDR_WIDTH-1:0]    w_off;
   logic                     w_unused_off;
   logic [PB-1:0]            w_part;
   logic [ENTRY_WIDTH-1:0]   w_entry;
   logic                     w_trig;
   logic                     w_in_range;
   logic [PB-1:0]            w_sel_part;
   logic [PARTITION_CNT-1:0] w_sel;
   logic [PARTITION_CNT*DATA_WIDTH-1:0] w_mux_data;
   logic [DATA_WIDTH-1:0]    w_mux_out;

   // Replace partition p of an entry with d; bits falling beyond the entry
   // width (partial last partition) are discarded.
   function automatic logic [MEM_WIDTH-1:0] put_slice(input logic [MEM_WIDTH-1:0] base,
                                                      input int p,
                                                      input logic [DATA_WIDTH-1:0] d);
      logic [MEM_WIDTH-1:0] r;
      r = base;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         if (p * DATA_WIDTH + b < MEM_WIDTH) r[p*DATA_WIDTH+b] = d[b];
      end
      return r;
   endfunction

   assign w_off        = addr_i - ADDR_WIDTH'(BASE_ADDR);
   assign w_unused_off = ^w_off;
   assign w_part       = w_off[BOFF +: PB];
   assign w_entry      = w_off[BOFF+PB +: ENTRY_WIDTH];
   assign w_trig       = (int'(w_part) == TRIG_PART);
   assign w_in_range   = (int'(w_part) < PARTITION_CNT);

   // Read-slice source: memory data while waiting on memory, the reset value
   // for a trigger read of an invalid entry, otherwise the snapshot. The
   // zero padding above MEM_WIDTH gives the zero-extended partial partition.
   always_comb begin
      w_mux_data = '0;
      w_sel_part = w_part;
      if (state_q == ST_MEM) begin
         w_mux_data[MEM_WIDTH-1:0] = mem_rd_data_i;
         w_sel_part                = part_q;
      end else if (w_trig && !entry_vld_i) begin
         w_mux_data[MEM_WIDTH-1:0] = RST_VALUE;
      end else begin
         w_mux_data[MEM_WIDTH-1:0] = snap_q;
      end
      for (int i = 0; i < PARTITION_CNT; i++) begin
         w_sel[i] = (w_sel_part == PB'(i));
      end
   end

   one_hot_mux #(
      .WIDTH (DATA_WIDTH),
      .CNT   (PARTITION_CNT)
   ) u_mux (
      .data_i (w_mux_data),
      .sel_i  (w_sel),
      .data_o (w_mux_out)
   );

   always_comb begin
      state_d       = state_q;
      snap_d        = snap_q;
      part_d        = part_q;
      rd_d          = rd_q;
      cnt_d         = cnt_q;
      ack_d         = 1'b0;
      rd_data_d     = '0;
      err_d         = 1'b0;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      mem_rd_en_d   = mem_rd_en_q;
      mem_wr_en_d   = mem_wr_en_q;
      mem_wr_data_d = mem_wr_data_q;
      case (state_q)
         ST_IDLE: begin
            if (req_vld_i) begin
               part_d  = w_part;
               rd_d    = rd_en_i;
               state_d = ST_RESP;
               ack_d   = 1'b1;
               if (!w_in_range) begin
                  err_d = 1'b1;
               end else if (w_trig && rd_en_i) begin
                  if (entry_vld_i) begin
                     state_d     = ST_MEM;
                     ack_d       = 1'b0;
                     cnt_d       = '0;
                     mem_req_d   = 1'b1;
                     mem_rd_en_d = 1'b1;
                     mem_wr_en_d = 1'b0;
                     mem_addr_d  = w_entry;
                  end else begin
                     snap_d    = RST_VALUE;
                     rd_data_d = w_mux_out;
                  end
               end else if (w_trig && wr_en_i) begin
                  if (!entry_write_protect_en_i) begin
                     state_d       = ST_MEM;
                     ack_d         = 1'b0;
                     cnt_d         = '0;
                     mem_req_d     = 1'b1;
                     mem_rd_en_d   = 1'b0;
                     mem_wr_en_d   = 1'b1;
                     mem_addr_d    = w_entry;
                     mem_wr_data_d = put_slice(snap_q, TRIG_PART, wr_data_i);
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (rd_en_i) begin
                  rd_data_d = w_mux_out;
               end else if (wr_en_i) begin
                  snap_d = put_slice(snap_q, int'(w_part), wr_data_i);
               end
            end
         end
         ST_MEM: begin
            if (mem_ack_vld_i) begin
               state_d     = ST_RESP;
               ack_d       = 1'b1;
               mem_req_d   = 1'b0;
               mem_rd_en_d = 1'b0;
               mem_wr_en_d = 1'b0;
               if (rd_q) begin
                  snap_d    = mem_rd_data_i;
                  rd_data_d = w_mux_out;
               end else begin
                  // Committed entry equals the snapshot with the new trigger slice.
                  snap_d = mem_wr_data_q;
               end
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TO_LAST)) begin
               state_d     = ST_RESP;
               ack_d       = 1'b1;
               err_d       = 1'b1;
               mem_req_d   = 1'b0;
               mem_rd_en_d = 1'b0;
               mem_wr_en_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         snap_q        <= RST_VALUE;
         part_q        <= '0;
         rd_q          <= 1'b0;
         cnt_q         <= '0;
         ack_q         <= 1'b0;
         rd_data_q     <= '0;
         err_q         <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         mem_rd_en_q   <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_data_q <= '0;
      end else begin
         state_q       <= state_d;
         snap_q        <= snap_d;
         part_q        <= part_d;
         rd_q          <= rd_d;
         cnt_q         <= cnt_d;
         ack_q         <= ack_d;
         rd_data_q     <= rd_data_d;
         err_q         <= err_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_wr_data_q <= mem_wr_data_d;
      end
   end

   assign ack_vld_o     = ack_q;
   assign rd_data_o     = rd_data_q;
   assign err_o         = err_q;
   assign busy_o        = !state_q[ST_IDLE_BIT];
   assign mem_req_vld_o = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_rd_en_o   = mem_rd_en_q;
   assign mem_wr_en_o   = mem_wr_en_q;
   assign mem_wr_data_o = mem_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_snapshot_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_snapshot_mem_bridge                                         |
// | Purpose : Directed self-checking bench for snapshot_mem_bridge with      |
// |           DATA_WIDTH=32, MEM_WIDTH=72, BASE_ADDR=0x100, TIMEOUT=8.       |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_snapshot_mem_bridge;

   localparam logic [71:0] RSTV = 72'h5A_01234567_89ABCDEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_vld = 1'b0;
   logic [11:0] addr = '0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        ack_vld;
   logic [31:0] rd_data;
   logic        err;
   logic        entry_vld = 1'b1;
   logic        wprot = 1'b0;
   logic        busy;
   logic        mem_req_vld;
   logic [7:0]  mem_addr;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [71:0] mem_wr_data;
   logic        mem_ack_vld = 1'b0;
   logic [71:0] mem_rd_data = '0;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   snapshot_mem_bridge #(
      .DATA_WIDTH     (32),
      .MEM_WIDTH      (72),
      .ADDR_WIDTH     (12),
      .ENTRY_WIDTH    (8),
      .BASE_ADDR      (32'h100),
      .TRIGGER_LSB    (1'b1),
      .TIMEOUT_CYCLES (8),
      .RST_VALUE      (RSTV)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .req_vld_i                (req_vld),
      .addr_i                   (addr),
      .rd_en_i                  (rd_en),
      .wr_en_i                  (wr_en),
      .wr_data_i                (wr_data),
      .ack_vld_o                (ack_vld),
      .rd_data_o                (rd_data),
      .err_o                    (err),
      .entry_vld_i              (entry_vld),
      .entry_write_protect_en_i (wprot),
      .busy_o                   (busy),
      .mem_req_vld_o            (mem_req_vld),
      .mem_addr_o               (mem_addr),
      .mem_rd_en_o              (mem_rd_en),
      .mem_wr_en_o              (mem_wr_en),
      .mem_wr_data_o            (mem_wr_data),
      .mem_ack_vld_i            (mem_ack_vld),
      .mem_rd_data_i            (mem_rd_data)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called one time unit after a rising edge; leaves the bench one time
   // unit after the edge that captured the request (response cycle T+1).
   task automatic do_req(input logic [11:0] a, input logic rd, input logic [31:0] d);
      req_vld = 1'b1;
      addr    = a;
      rd_en   = rd;
      wr_en   = !rd;
      wr_data = d;
      @(posedge clk); #1;
      req_vld = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
   endtask

   task automatic step;
      @(posedge clk); #1;
   endtask

   // Non-memory access: ack, data and error expected in the very next cycle.
   task automatic simple(input string tag, input logic [11:0] a, input logic rd,
                         input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
      do_req(a, rd, d);
      check({tag, ".ack"}, ack_vld, 1'b1);
      check({tag, ".rd"},  rd_data, exp_rd);
      check({tag, ".err"}, err, exp_err);
      check({tag, ".mreq"}, mem_req_vld, 1'b0);
      step;
   endtask

   initial begin
      int req_cnt;
      int ack_at;

      step; step;
      check("rst.ack",   ack_vld, 1'b0);
      check("rst.rd",    rd_data, 32'h0);
      check("rst.err",   err, 1'b0);
      check("rst.busy",  busy, 1'b0);
      check("rst.mreq",  mem_req_vld, 1'b0);
      check("rst.maddr", mem_addr, 8'h0);
      check("rst.men",   {mem_rd_en, mem_wr_en}, 2'b00);
      check("rst.mwd",   mem_wr_data, 72'h0);
      rst_n = 1'b1;
      step;

      // Trigger read of entry 1 with memory ack in the third cycle.
      do_req(12'h110, 1'b1, 32'h0);
      check("trd.mreq",  mem_req_vld, 1'b1);
      check("trd.maddr", mem_addr, 8'd1);
      check("trd.mrd",   {mem_rd_en, mem_wr_en}, 2'b10);
      check("trd.busy",  busy, 1'b1);
      check("trd.noack", ack_vld, 1'b0);
      step;
      mem_ack_vld = 1'b1;
      mem_rd_data = 72'hAB_DEADBEEF_12345678;
      step;
      mem_ack_vld = 1'b0;
      mem_rd_data = '0;
      check("trd.ack", ack_vld, 1'b1);
      check("trd.rd",  rd_data, 32'h12345678);
      check("trd.err", err, 1'b0);
      step;
      check("trd.idle", {ack_vld, rd_data, busy}, 34'h0);
      simple("p2rd", 12'h118, 1'b1, 32'h0, 32'h000000AB, 1'b0);

      // Staged write then trigger write commit.
      simple("p1wr", 12'h114, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
      do_req(12'h110, 1'b0, 32'h11112222);
      check("twr.mreq", mem_req_vld, 1'b1);
      check("twr.men",  {mem_rd_en, mem_wr_en}, 2'b01);
      check("twr.maddr", mem_addr, 8'd1);
      check("twr.mwd",  mem_wr_data, 72'hAB_CAFEF00D_11112222);
      mem_ack_vld = 1'b1;
      step;
      mem_ack_vld = 1'b0;
      check("twr.hold", mem_req_vld, 1'b0);
      check("twr.ack",  ack_vld, 1'b1);
      check("twr.err",  err, 1'b0);
      step;

      // Protected trigger write: no memory traffic, error ack.
      wprot = 1'b1;
      simple("prot", 12'h110, 1'b0, 32'h99999999, 32'h0, 1'b1);
      wprot = 1'b0;
      simple("p1rd", 12'h114, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0);

      // Timeout on a trigger read of entry 2.
      do_req(12'h120, 1'b1, 32'h0);
      req_cnt = 0;
      ack_at  = -1;
      for (int i = 0; i < 12; i++) begin
         if (mem_req_vld) req_cnt++;
         if (ack_vld && ack_at < 0) begin
            ack_at = i;
            check("to.err", err, 1'b1);
            check("to.rd",  rd_data, 32'h0);
         end
         step;
      end
      check("to.reqcyc", req_cnt, 8);
      check("to.ackcyc", ack_at, 8);
      mem_ack_vld = 1'b1;
      mem_rd_data = 72'hFF_FFFFFFFF_FFFFFFFF;
      step;
      mem_ack_vld = 1'b0;
      mem_rd_data = '0;
      check("stray.ack1", {ack_vld, busy}, 2'b00);
      step;
      check("stray.ack2", {ack_vld, busy}, 2'b00);
      simple("to.snap", 12'h114, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0);

      // Partial last partition, out-of-range partition.
      simple("p2wr",   12'h118, 1'b0, 32'hFFFFFF3C, 32'h0, 1'b0);
      simple("p2rd2",  12'h118, 1'b1, 32'h0, 32'h0000003C, 1'b0);
      simple("oorrd",  12'h11C, 1'b1, 32'h0, 32'h0, 1'b1);
      simple("oorwr",  12'h11C, 1'b0, 32'h77777777, 32'h0, 1'b1);
      simple("p2rd3",  12'h118, 1'b1, 32'h0, 32'h0000003C, 1'b0);

      // Trigger read of an invalid entry loads the reset value.
      entry_vld = 1'b0;
      simple("inv",    12'h110, 1'b1, 32'h0, 32'h89ABCDEF, 1'b0);
      entry_vld = 1'b1;
      simple("inv.p1", 12'h114, 1'b1, 32'h0, 32'h01234567, 1'b0);
      simple("inv.p2", 12'h118, 1'b1, 32'h0, 32'h0000005A, 1'b0);

      // Reset in the middle of a memory access.
      simple("pre.wr", 12'h114, 1'b0, 32'h55555555, 32'h0, 1'b0);
      do_req(12'h130, 1'b1, 32'h0);
      check("mid.mreq", mem_req_vld, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid.outs", {ack_vld, err, busy, mem_req_vld, mem_rd_en, mem_wr_en}, 6'h0);
      check("mid.maddr", mem_addr, 8'h0);
      check("mid.rd", rd_data, 32'h0);
      step;
      check("mid.noack", ack_vld, 1'b0);
      rst_n = 1'b1;
      step;
      simple("post.p1", 12'h114, 1'b1, 32'h0, 32'h01234567, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/snapshot_mem_bridge.md
# snapshot_mem_bridge

Parametrised register-to-memory snapshot bridge between the register-file access bus and an entry-organised memory whose entries are wider than one register word. A read of the trigger partition fetches a whole memory entry into a snapshot buffer atomically; the remaining partitions are then served from the buffer. Writes to non-trigger partitions are staged in the buffer, and a write to the trigger partition commits the full entry. It adds to the earlier generation a selectable trigger partition, a memory-ack timeout, an error response, and out-of-range partition handling.

## Interface
- DATA_WIDTH, 32, register bus word width (multiple of 8)
- MEM_WIDTH, 72, memory entry width; PARTITION_CNT = ceil(MEM_WIDTH/DATA_WIDTH), REM_WIDTH = MEM_WIDTH % DATA_WIDTH
- ADDR_WIDTH, 12, byte address width
- ENTRY_WIDTH, 8, memory entry index width
- BASE_ADDR, 0, subtracted from addr before decoding
- TRIGGER_LSB, 1, 1: partition 0 triggers memory access; 0: partition PARTITION_CNT-1 triggers
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack_vld; 0 disables the timeout
- RST_VALUE, 0, snapshot reset value, and data substituted when entry_vld=0
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  access request, one-cycle pulse
- addr  in  ADDR_WIDTH  byte address
- rd_en / wr_en  in  1  access type, qualified by req_vld, mutually exclusive
- wr_data  in  DATA_WIDTH  write data
- ack_vld  out  1  one-cycle completion pulse
- rd_data  out  DATA_WIDTH  read data, valid with ack_vld
- err  out  1  error flag, valid with ack_vld
- entry_vld  in  1  entry holds valid content
- entry_write_protect_en  in  1  blocks memory commit
- busy  out  1  high while not IDLE
- mem_req_vld  out  1  memory request, held until ack or timeout
- mem_addr  out  ENTRY_WIDTH  entry index
- mem_rd_en / mem_wr_en  out  1  memory operation type
- mem_wr_data  out  MEM_WIDTH  full entry write data
- mem_ack_vld  in  1  memory completion
- mem_rd_data  in  MEM_WIDTH  read data, valid with mem_ack_vld

## Operation
- Address decode: off = addr - BASE_ADDR; BOFF = log2(DATA_WIDTH/8); PB = log2(PARTITION_CNT), rounded up.
  - part = off[BOFF+PB-1:BOFF]
  - entry = off[BOFF+PB +: ENTRY_WIDTH]
- Request capture: part, entry, rd/wr and wr_data are registered in IDLE when req_vld=1.
- FSM, one-hot, states IDLE, MEM, RESP:
  - IDLE→MEM: trigger-partition read with entry_vld=1, or trigger-partition write with entry_write_protect_en=0.
  - IDLE→RESP: any other request.
  - MEM→RESP: on mem_ack_vld, or on timeout.
  - RESP→IDLE: always.
- Non-trigger partition:
  - Read returns the snapshot slice.
  - Write updates the snapshot slice; no memory traffic.
- Trigger read, entry_vld=1: mem_rd_en=1. On mem_ack_vld the whole snapshot loads mem_rd_data; the trigger slice is returned.
- Trigger read, entry_vld=0: snapshot loads RST_VALUE; the trigger slice of RST_VALUE is returned; err=0.
- Trigger write, not protected: mem_wr_en=1; mem_wr_data = snapshot with the trigger slice replaced by the captured wr_data. On mem_ack_vld the snapshot trigger slice is updated.
- Trigger write, protected: no memory access; snapshot unchanged; ack with err=1.
- Out-of-range partition (part ≥ PARTITION_CNT): read returns 0; write is dropped; err=1.
- Partial last partition: rd_data is zero-padded above REM_WIDTH; wr_data bits above REM_WIDTH are ignored.
- Timeout:
  - A counter runs in MEM; on reaching TIMEOUT_CYCLES, mem_req_vld drops and RESP is entered with err=1.
  - Read returns 0 and the snapshot is unchanged.
  - A later stray mem_ack_vld in IDLE/RESP is ignored.

## Timing
- Reset values: ack_vld=0, rd_data=0, err=0, busy=0, mem_req_vld=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0. State=IDLE, snapshot=RST_VALUE, timeout counter=0.
- No memory access: req_vld at cycle T → ack_vld at T+1.
- Memory access: mem_req_vld and mem_addr/en/data are registered and held constant over T+1..T+k. mem_ack_vld at T+k (k≥1) → ack_vld at T+k+1.
- Timeout: err ack at T+TIMEOUT_CYCLES+1.
- req_vld while busy=1 is ignored; upstream waits for ack_vld.
- rd_data and err are registered; both are zero outside the ack_vld cycle.
- Reset asserted mid-transaction aborts immediately to reset values; no ack is generated.

## Structure
- Shared header snapshot_mem_defs.vh holds:
  - state encodings IDLE/MEM/RESP and their bit indices
  - the log2 helper from common_funcs.vh
  - the PARTITION_CNT/REM_WIDTH derivation macro
- Sub-module one_hot_mux (WIDTH=DATA_WIDTH, CNT=PARTITION_CNT) selects the read slice from the zero-padded snapshot, using the decoded one-hot part.

## Test plan
All scenarios use DATA_WIDTH=32, MEM_WIDTH=72, TRIGGER_LSB=1, BASE_ADDR=0x100, TIMEOUT_CYCLES=8.
- Read addr 0x110 (entry 1, part 0), entry_vld=1, mem_ack at +3 with mem_rd_data=0xAB_DEADBEEF_12345678 → mem_addr=1, mem_rd_en=1; ack_vld at +4, rd_data=0x12345678. Then read 0x118 → rd_data=0x000000AB at T+1, no mem_req_vld.
- Write 0x114 with 0xCAFEF00D, then write 0x110 with 0x11112222, mem_ack at +2 → mem_wr_en=1, mem_wr_data=0x??_CAFEF00D_11112222 (bits 71:64 = current snapshot); ack at +3, err=0.
- Trigger write with entry_write_protect_en=1 → no mem_req_vld; ack_vld at T+1 with err=1; snapshot unchanged.
- Trigger read, mem_ack_vld never asserted → mem_req_vld high 8 cycles then low; ack_vld with err=1, rd_data=0. Stray mem_ack afterward → no ack_vld.
- Read 0x11C (part 3, out of range) → ack at T+1, rd_data=0, err=1. Trigger read with entry_vld=0 → no memory access, rd_data = RST_VALUE[31:0].
- rst_n pulsed low during MEM → all outputs zero immediately; subsequent non-trigger read returns the RST_VALUE slice.
